// File: rtl/cpu_rf_pkg.sv
// Shared register-file types: register count, index/one-hot types, decode helpers.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package cpu_rf_pkg;

  localparam int REG_CNT = 16;

  typedef logic [3:0]         reg_idx_t;
  typedef logic [REG_CNT-1:0] reg_onehot_t;

  // True when exactly one bit is set; all-zero is not one-hot.
  function automatic logic is_onehot(input reg_onehot_t v);
    return (v != '0) && ((v & (v - reg_onehot_t'(1))) == '0);
  endfunction

  // Encode a one-hot vector to its index; only meaningful when is_onehot(v).
  function automatic reg_idx_t onehot_to_idx(input reg_onehot_t v);
    reg_idx_t idx;
    idx = '0;
    for (int i = 0; i < REG_CNT; i++) begin
      if (v[i]) idx = idx | reg_idx_t'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/reg_scoreboard_16.sv
// Busy scoreboard for 16 registers: reserve sets, legal write-back clears, hazard lookup.
// Latency: busy is registered; hazard lookup is combinational (post-clear, pre-reserve view).
// Backpressure: none; set/clear applied every cycle, reserve wins over clear on the same index.
module reg_scoreboard_16
  import cpu_rf_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr_en,
  input  reg_onehot_t clr_vec,
  input  logic        rsv_en,
  input  reg_idx_t    rsv_addr,
  input  reg_idx_t    look_a,
  input  reg_idx_t    look_b,
  output logic        hz_a,
  output logic        hz_b,
  output reg_onehot_t busy
);

  reg_onehot_t busy_q;
  reg_onehot_t busy_clr;
  reg_onehot_t busy_nxt;

  // Apply this cycle's write-back clear first, then the reserve so it takes priority.
  always_comb begin
    busy_clr = clr_en ? (busy_q & ~clr_vec) : busy_q;
    busy_nxt = busy_clr;
    if (rsv_en) busy_nxt[rsv_addr] = 1'b1;
  end

  // Hazards see the same-cycle clear but not the same-cycle reserve.
  always_comb begin
    hz_a = busy_clr[look_a];
    hz_b = busy_clr[look_b];
  end

  // Scoreboard state register.
  always_ff @(posedge clk) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_nxt;
  end

  assign busy = busy_q;

endmodule

// File: rtl/reg_bank_16.sv
// 16-entry register bank: one-hot write port, two registered read ports with write bypass, busy scoreboard.
// Latency: reads return 1 cycle after rd_req; writes visible to reads in the same cycle via bypass.
// Backpressure: none; every request is accepted, illegal multi-hot writes are dropped and flagged in wr_err.
module reg_bank_16
  import cpu_rf_pkg::*;
#(
  parameter int                 DATA_W  = 16,
  parameter logic [DATA_W-1:0]  RST_VAL = '0
)
(
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       R_en,
  input  logic [DATA_W-1:0] w_data,
  input  logic              rd_req,
  input  logic [3:0]        rd_addr_a,
  input  logic [3:0]        rd_addr_b,
  input  logic              rsv_en,
  input  logic [3:0]        rsv_addr,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  output logic              rd_valid,
  output logic              hazard_a,
  output logic              hazard_b,
  output logic [15:0]       busy,
  output logic              wr_err
);

  typedef struct packed {
    logic [DATA_W-1:0] data_a;
    logic [DATA_W-1:0] data_b;
    logic              hazard_a;
    logic              hazard_b;
  } rd_out_t;

  logic [DATA_W-1:0] regs [REG_CNT];

  logic     wr_legal;
  reg_idx_t wr_idx;
  logic     hz_a;
  logic     hz_b;
  rd_out_t  rd_nxt;
  rd_out_t  rd_q;
  logic     valid_q;
  logic     err_q;

  assign wr_legal = is_onehot(R_en);
  assign wr_idx   = onehot_to_idx(R_en);

  reg_scoreboard_16 u_sb (
    .clk      (clk),
    .rst      (rst),
    .clr_en   (wr_legal),
    .clr_vec  (R_en),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .look_a   (rd_addr_a),
    .look_b   (rd_addr_b),
    .hz_a     (hz_a),
    .hz_b     (hz_b),
    .busy     (busy)
  );

  // Read muxes with write-through bypass; a multi-hot write never bypasses.
  always_comb begin
    rd_nxt.data_a   = (wr_legal && R_en[rd_addr_a]) ? w_data : regs[rd_addr_a];
    rd_nxt.data_b   = (wr_legal && R_en[rd_addr_b]) ? w_data : regs[rd_addr_b];
    rd_nxt.hazard_a = hz_a;
    rd_nxt.hazard_b = hz_b;
  end

  // Storage array: only a legal one-hot enable writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_CNT; i++) regs[i] <= RST_VAL;
    end else if (wr_legal) begin
      regs[wr_idx] <= w_data;
    end
  end

  // Read output registers: capture on request, hold otherwise; reset drops any read in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      rd_q    <= '0;
    end else begin
      valid_q <= rd_req;
      if (rd_req) rd_q <= rd_nxt;
    end
  end

  // Sticky error for a write enable with more than one bit set.
  always_ff @(posedge clk) begin
    if (rst)                           err_q <= 1'b0;
    else if (R_en != '0 && !wr_legal)  err_q <= 1'b1;
  end

  assign rd_valid  = valid_q;
  assign rd_data_a = rd_q.data_a;
  assign rd_data_b = rd_q.data_b;
  assign hazard_a  = rd_q.hazard_a;
  assign hazard_b  = rd_q.hazard_b;
  assign wr_err    = err_q;

endmodule

// File: tb/tb_reg_bank_16.sv
// Bench for reg_bank_16: directed vector table for the key corner cases, then random traffic vs a model.
// Latency: expected outputs are those seen just after the edge that samples each vector.
// Backpressure: n/a.
module tb_reg_bank_16;

  localparam int DW = 16;

  logic          clk;
  logic          rst;
  logic [15:0]   R_en;
  logic [DW-1:0] w_data;
  logic          rd_req;
  logic [3:0]    rd_addr_a;
  logic [3:0]    rd_addr_b;
  logic          rsv_en;
  logic [3:0]    rsv_addr;
  logic [DW-1:0] rd_data_a;
  logic [DW-1:0] rd_data_b;
  logic          rd_valid;
  logic          hazard_a;
  logic          hazard_b;
  logic [15:0]   busy;
  logic          wr_err;

  int n_vec = 0;
  int n_cmp = 0;
  int n_bad = 0;

  reg_bank_16 #(.DATA_W(DW), .RST_VAL('0)) dut (
    .clk       (clk),
    .rst       (rst),
    .R_en      (R_en),
    .w_data    (w_data),
    .rd_req    (rd_req),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .rsv_en    (rsv_en),
    .rsv_addr  (rsv_addr),
    .rd_data_a (rd_data_a),
    .rd_data_b (rd_data_b),
    .rd_valid  (rd_valid),
    .hazard_a  (hazard_a),
    .hazard_b  (hazard_b),
    .busy      (busy),
    .wr_err    (wr_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        rst;
    logic [15:0] en;
    logic [15:0] wd;
    logic        rq;
    logic [3:0]  a;
    logic [3:0]  b;
    logic        rv;
    logic [3:0]  ra;
    logic        ev;
    logic [15:0] ea;
    logic [15:0] eb;
    logic        eha;
    logic        ehb;
    logic [15:0] ebusy;
    logic        eerr;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(
    input logic rs, input logic [15:0] en, input logic [15:0] wd,
    input logic rq, input logic [3:0] a, input logic [3:0] b,
    input logic rv, input logic [3:0] ra,
    input logic ev, input logic [15:0] ea, input logic [15:0] eb,
    input logic eha, input logic ehb, input logic [15:0] ebusy, input logic eerr);
    vec_t v;
    v.rst = rs; v.en = en; v.wd = wd; v.rq = rq; v.a = a; v.b = b; v.rv = rv; v.ra = ra;
    v.ev = ev; v.ea = ea; v.eb = eb; v.eha = eha; v.ehb = ehb; v.ebusy = ebusy; v.eerr = eerr;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic rs, input logic [15:0] en, input logic [15:0] wd,
                       input logic rq, input logic [3:0] a, input logic [3:0] b,
                       input logic rv, input logic [3:0] ra);
    rst = rs; R_en = en; w_data = wd; rd_req = rq;
    rd_addr_a = a; rd_addr_b = b; rsv_en = rv; rsv_addr = ra;
  endtask

  task automatic check_all(input string tag, input int idx,
                           input logic ev, input logic [15:0] ea, input logic [15:0] eb,
                           input logic eha, input logic ehb, input logic [15:0] ebusy, input logic eerr);
    chk({tag, ".rd_valid"},  idx, 32'(rd_valid),  32'(ev));
    chk({tag, ".rd_data_a"}, idx, 32'(rd_data_a), 32'(ea));
    chk({tag, ".rd_data_b"}, idx, 32'(rd_data_b), 32'(eb));
    chk({tag, ".hazard_a"},  idx, 32'(hazard_a),  32'(eha));
    chk({tag, ".hazard_b"},  idx, 32'(hazard_b),  32'(ehb));
    chk({tag, ".busy"},      idx, 32'(busy),      32'(ebusy));
    chk({tag, ".wr_err"},    idx, 32'(wr_err),    32'(eerr));
  endtask

  // Behavioural reference: register array, busy bit array, sticky error, last read result.
  logic [15:0] m_reg [16];
  logic [15:0] m_busy;
  logic        m_err;
  logic        m_v;
  logic [15:0] m_a;
  logic [15:0] m_b;
  logic        m_ha;
  logic        m_hb;

  task automatic model_edge();
    int pc;
    int wi;
    pc = $countones(R_en);
    wi = -1;
    if (rst) begin
      for (int i = 0; i < 16; i++) m_reg[i] = '0;
      m_busy = '0; m_err = 1'b0; m_v = 1'b0;
      m_a = '0; m_b = '0; m_ha = 1'b0; m_hb = 1'b0;
    end else begin
      if (pc == 1) begin
        for (int i = 0; i < 16; i++) if (R_en[i]) wi = i;
      end
      m_v = rd_req;
      if (rd_req) begin
        m_a  = (wi == int'(rd_addr_a)) ? w_data : m_reg[rd_addr_a];
        m_b  = (wi == int'(rd_addr_b)) ? w_data : m_reg[rd_addr_b];
        m_ha = m_busy[rd_addr_a] && (wi != int'(rd_addr_a));
        m_hb = m_busy[rd_addr_b] && (wi != int'(rd_addr_b));
      end
      if (wi >= 0) begin
        m_reg[wi]  = w_data;
        m_busy[wi] = 1'b0;
      end
      if (rsv_en) m_busy[rsv_addr] = 1'b1;
      if (pc > 1) m_err = 1'b1;
    end
  endtask

  initial begin
    logic [15:0] one;
    logic [15:0] en;
    int r;
    one = 16'h0001;
    drive(1'b1, 16'h0, 16'h0, 1'b0, 4'd0, 4'd0, 1'b0, 4'd0);

    //       rst en        wd        rq a  b   rv ra   ev ea        eb        ha hb busy      err
    tbl.push_back(mk(1, 16'h0000, 16'h0000, 0, 0, 0,  0, 0,   0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 0));
    tbl.push_back(mk(0, 16'h0000, 16'h0000, 1, 3, 15, 0, 0,   1, 16'h0000, 16'h0000, 0, 0, 16'h0000, 0));
    tbl.push_back(mk(0, 16'h0020, 16'hBEEF, 0, 0, 0,  0, 0,   0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 0));
    tbl.push_back(mk(0, 16'h0000, 16'h0000, 1, 5, 0,  0, 0,   1, 16'hBEEF, 16'h0000, 0, 0, 16'h0000, 0));
    tbl.push_back(mk(0, 16'h0100, 16'h1234, 1, 8, 8,  0, 0,   1, 16'h1234, 16'h1234, 0, 0, 16'h0000, 0));
    tbl.push_back(mk(0, 16'h0000, 16'h0000, 0, 0, 0,  1, 2,   0, 16'h1234, 16'h1234, 0, 0, 16'h0004, 0));
    tbl.push_back(mk(0, 16'h0000, 16'h0000, 1, 2, 5,  0, 0,   1, 16'h0000, 16'hBEEF, 1, 0, 16'h0004, 0));
    tbl.push_back(mk(0, 16'h0004, 16'hAAAA, 0, 0, 0,  0, 0,   0, 16'h0000, 16'hBEEF, 1, 0, 16'h0000, 0));
    tbl.push_back(mk(0, 16'h0000, 16'h0000, 1, 2, 2,  0, 0,   1, 16'hAAAA, 16'hAAAA, 0, 0, 16'h0000, 0));
    tbl.push_back(mk(0, 16'h0000, 16'h0000, 0, 0, 0,  1, 9,   0, 16'hAAAA, 16'hAAAA, 0, 0, 16'h0200, 0));
    tbl.push_back(mk(0, 16'h0200, 16'h5555, 1, 9, 9,  0, 0,   1, 16'h5555, 16'h5555, 0, 0, 16'h0000, 0));
    tbl.push_back(mk(0, 16'h0000, 16'h0000, 1, 3, 3,  1, 3,   1, 16'h0000, 16'h0000, 0, 0, 16'h0008, 0));
    tbl.push_back(mk(0, 16'h0080, 16'h7777, 0, 0, 0,  1, 7,   0, 16'h0000, 16'h0000, 0, 0, 16'h0088, 0));
    tbl.push_back(mk(0, 16'h0000, 16'h0000, 1, 7, 3,  0, 0,   1, 16'h7777, 16'h0000, 1, 1, 16'h0088, 0));
    tbl.push_back(mk(0, 16'h0003, 16'hFFFF, 0, 0, 0,  0, 0,   0, 16'h7777, 16'h0000, 1, 1, 16'h0088, 1));
    tbl.push_back(mk(0, 16'h0000, 16'h0000, 1, 0, 1,  0, 0,   1, 16'h0000, 16'h0000, 0, 0, 16'h0088, 1));
    tbl.push_back(mk(0, 16'h0000, 16'h0000, 1, 0, 1,  0, 0,   1, 16'h0000, 16'h0000, 0, 0, 16'h0088, 1));
    tbl.push_back(mk(0, 16'h0003, 16'hFFFF, 1, 0, 1,  0, 0,   1, 16'h0000, 16'h0000, 0, 0, 16'h0088, 1));
    tbl.push_back(mk(0, 16'h0000, 16'h0000, 1, 7, 7,  0, 0,   1, 16'h7777, 16'h7777, 1, 1, 16'h0088, 1));
    tbl.push_back(mk(1, 16'h0000, 16'h0000, 1, 7, 7,  0, 0,   0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 0));
    tbl.push_back(mk(0, 16'h0000, 16'h0000, 0, 0, 0,  0, 0,   0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].rst, tbl[i].en, tbl[i].wd, tbl[i].rq, tbl[i].a, tbl[i].b, tbl[i].rv, tbl[i].ra);
      @(posedge clk);
      #1;
      n_vec++;
      check_all("dir", i, tbl[i].ev, tbl[i].ea, tbl[i].eb, tbl[i].eha, tbl[i].ehb, tbl[i].ebusy, tbl[i].eerr);
    end

    // Random phase starts from a reset so the model and DUT share a known state.
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 99);
      if (r < 40)      en = 16'h0000;
      else if (r < 85) en = one << $urandom_range(0, 15);
      else             en = 16'($urandom);
      drive((i == 0) || ($urandom_range(0, 199) == 0),
            en, 16'($urandom), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 3)) : 4'($urandom),
            ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 3)) : 4'($urandom),
            ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 3)) : 4'($urandom));
      @(posedge clk);
      model_edge();
      #1;
      n_vec++;
      check_all("rnd", i, m_v, m_a, m_b, m_ha, m_hb, m_busy, m_err);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
